// File: rtl/lsu_dmem_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dmem_master
// Brief    : Single-outstanding load/store master for a 64-bit data memory.
//            It checks alignment and the address window, places byte lanes
//            and sign- or zero-extends load data.
//            Optional perf counters are enabled by defining LSU_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module lsu_dmem_master #(
    parameter logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000,
    parameter logic [63:0] MEM_SIZE = 64'h0000_0000_0800_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        dmem_en,
    output logic [63:0] dmem_addr,
    input  logic [63:0] dmem_rdata,
    output logic [63:0] dmem_wdata,
    output logic [63:0] dmem_wmask,
    output logic        dmem_wen,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // One past the last legal byte; 65 bits so the sum cannot wrap.
    localparam logic [64:0] c_win_end = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_wen;
    logic [63:0] r_wdata_sh;
    logic [63:0] r_wmask_sh;
    logic [63:0] r_rdata;
    logic        r_err;

    logic        w_hs;
    logic        w_resp_hs;
    logic        w_aligned;
    logic        w_legal;
    logic [3:0]  w_nbytes;
    logic [64:0] w_end;
    logic [63:0] w_lane_mask;
    logic [63:0] w_rd_sh;
    logic [63:0] w_load_ext;

    assign w_hs      = req_valid && (r_state == IDLE);
    assign w_resp_hs = (r_state == RESP) && resp_ready;
    assign w_nbytes  = 4'd1 << req_size;
    assign w_end     = {1'b0, req_addr} + {61'd0, w_nbytes};

    always_comb begin
        w_aligned   = 1'b1;
        w_lane_mask = 64'hFF;
        case (req_size)
            2'd0: begin w_aligned = 1'b1;                 w_lane_mask = 64'h0000_0000_0000_00FF; end
            2'd1: begin w_aligned = (req_addr[0] == 1'b0);   w_lane_mask = 64'h0000_0000_0000_FFFF; end
            2'd2: begin w_aligned = (req_addr[1:0] == 2'b0); w_lane_mask = 64'h0000_0000_FFFF_FFFF; end
            default: begin w_aligned = (req_addr[2:0] == 3'b0); w_lane_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
    end

    assign w_legal = w_aligned && (req_addr >= MEM_BASE) && (w_end <= c_win_end);

    // Load data arrives on the 8-byte-aligned bus; bring the addressed bytes to bit 0.
    assign w_rd_sh = dmem_rdata >> {r_addr[2:0], 3'b000};

    always_comb begin
        w_load_ext = 64'd0;
        case (r_size)
            2'd0: w_load_ext = r_signed ? {{56{w_rd_sh[7]}},  w_rd_sh[7:0]}  : {56'd0, w_rd_sh[7:0]};
            2'd1: w_load_ext = r_signed ? {{48{w_rd_sh[15]}}, w_rd_sh[15:0]} : {48'd0, w_rd_sh[15:0]};
            2'd2: w_load_ext = r_signed ? {{32{w_rd_sh[31]}}, w_rd_sh[31:0]} : {32'd0, w_rd_sh[31:0]};
            default: w_load_ext = w_rd_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_state_nxt = w_legal ? ACCESS : RESP;
            ACCESS:  w_state_nxt = RESP;
            RESP:    if (resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= 64'd0;
            r_size     <= 2'd0;
            r_signed   <= 1'b0;
            r_wen      <= 1'b0;
            r_wdata_sh <= 64'd0;
            r_wmask_sh <= 64'd0;
            r_rdata    <= 64'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_hs) begin
                r_addr     <= req_addr;
                r_size     <= req_size;
                r_signed   <= req_signed;
                r_wen      <= req_wen;
                r_wdata_sh <= req_wdata << {req_addr[2:0], 3'b000};
                r_wmask_sh <= w_lane_mask << {req_addr[2:0], 3'b000};
                r_err      <= !w_legal;
                r_rdata    <= 64'd0;
            end
            if (r_state == ACCESS) begin
                r_err   <= 1'b0;
                r_rdata <= r_wen ? 64'd0 : w_load_ext;
            end
            if (w_resp_hs) begin
                r_err <= 1'b0;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign dmem_en    = (r_state == ACCESS);
    assign dmem_wen   = (r_state == ACCESS) && r_wen;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata_sh;
    assign dmem_wmask = r_wmask_sh;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] r_perf_loads;
    logic [31:0] r_perf_stores;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_loads  <= 32'd0;
            r_perf_stores <= 32'd0;
        end else if (w_resp_hs && !r_err) begin
            if (r_wen) begin
                r_perf_stores <= r_perf_stores + 32'd1;
            end else begin
                r_perf_loads  <= r_perf_loads + 32'd1;
            end
        end
    end

    assign perf_loads  = r_perf_loads;
    assign perf_stores = r_perf_stores;
`else
    assign perf_loads  = 32'd0;
    assign perf_stores = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_dmem_master
// Brief    : Scoreboard bench for lsu_dmem_master against a byte-array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_dmem_master;

    localparam logic [63:0] c_base = 64'h0000_0000_8000_0000;
    localparam logic [63:0] c_size = 64'h0000_0000_0800_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        dmem_en;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_rdata;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_wmask;
    logic        dmem_wen;
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;

    always #5 clk = ~clk;

    lsu_dmem_master #(.MEM_BASE(c_base), .MEM_SIZE(c_size)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_wen(dmem_wen),
        .perf_loads(perf_loads), .perf_stores(perf_stores)
    );

    // 256-byte memory; the window aliases onto it through address bits [7:3].
    logic [63:0] wmem [32] = '{default: 64'h0};
    logic [4:0]  widx;
    assign widx       = dmem_addr[7:3];
    assign dmem_rdata = wmem[widx];

    always @(posedge clk) begin
        if (dmem_en && dmem_wen)
            wmem[widx] <= (wmem[widx] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
    end

    // Reference model: plain byte array updated by request semantics.
    logic [7:0] rmem [256] = '{default: 8'h00};

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
        logic        wen;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_loads = 0;
    int   exp_stores = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted response.
    initial begin : monitor
        logic        pv, pr, pe;
        logic [63:0] prd;
        exp_t        e;
        pv = 0; pr = 0; pe = 0; prd = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0;
            end else begin
                if (resp_valid) begin
                    chk("req_ready_low_in_resp", {63'd0, req_ready}, 64'd0);
                    if (pv && !pr) begin
                        chk("resp_rdata_stable", resp_rdata, prd);
                        chk("resp_err_stable", {63'd0, resp_err}, {63'd0, pe});
                    end
                    if (resp_ready) begin
                        if (q.size() == 0) begin
                            chk("unexpected_resp", 64'd1, 64'd0);
                        end else begin
                            e = q.pop_front();
                            chk("resp_rdata", resp_rdata, e.rdata);
                            chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
                            if (!e.err) begin
                                if (e.wen) exp_stores++;
                                else       exp_loads++;
                            end
                        end
                    end
                end
                pv = resp_valid; pr = resp_ready; prd = resp_rdata; pe = resp_err;
            end
        end
    end

    task automatic issue(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [63:0] wdata, input int hold);
        int          n, off, lane;
        logic        legal, ok;
        logic [63:0] val, m, wd;
        exp_t        e;
        n     = 1 << size;
        off   = int'(addr[7:0]);
        lane  = int'(addr[2:0]);
        legal = (addr % 64'(n) == 64'd0) && (addr >= c_base) &&
                ({1'b0, addr} + 65'(n) <= {1'b0, c_base} + {1'b0, c_size});
        val = 64'd0; m = 64'd0; wd = 64'd0;
        if (!legal) begin
            e = '{rdata: 64'd0, err: 1'b1, wen: wen};
        end else if (wen) begin
            e = '{rdata: 64'd0, err: 1'b0, wen: 1'b1};
            for (int i = 0; i < n; i++) begin
                m[8*(lane+i) +: 8]  = 8'hFF;
                wd[8*(lane+i) +: 8] = wdata[8*i +: 8];
            end
        end else begin
            for (int i = 0; i < n; i++) val = val | (64'(rmem[(off+i)%256]) << (8*i));
            if (sgn && n < 8 && val[8*n-1]) val = val | (~64'd0 << (8*n));
            e = '{rdata: val, err: 1'b0, wen: 1'b0};
        end

        req_valid = 1; req_wen = wen; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wdata;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = req_ready;
        end
        if (!ok) begin
            chk("req_ready_timeout", 64'd0, 64'd1);
            req_valid = 0;
            return;
        end
        q.push_back(e);
        @(posedge clk); #1;
        req_valid = 0;
        if (legal) begin
            chk("dmem_en_n1", {63'd0, dmem_en}, 64'd1);
            chk("dmem_addr_n1", dmem_addr, addr);
            chk("dmem_wen_n1", {63'd0, dmem_wen}, {63'd0, wen});
            chk("resp_valid_low_n1", {63'd0, resp_valid}, 64'd0);
            if (wen) begin
                chk("dmem_wmask", dmem_wmask, m);
                chk("dmem_wdata_lanes", dmem_wdata & m, wd);
            end
            @(posedge clk); #1;
            chk("resp_valid_n2", {63'd0, resp_valid}, 64'd1);
            chk("dmem_en_low_n2", {63'd0, dmem_en}, 64'd0);
            if (wen)
                for (int i = 0; i < n; i++) rmem[(off+i)%256] = wdata[8*i +: 8];
        end else begin
            chk("err_resp_valid_n1", {63'd0, resp_valid}, 64'd1);
            chk("err_dmem_en_n1", {63'd0, dmem_en}, 64'd0);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("dmem_en_low_hold", {63'd0, dmem_en}, 64'd0);
        end
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
    endtask

    task automatic check_mem();
        logic [63:0] w;
        for (int k = 0; k < 32; k++) begin
            w = 64'd0;
            for (int b = 0; b < 8; b++) w = w | (64'(rmem[8*k+b]) << (8*b));
            chk($sformatf("mem_word_%0d", k), wmem[k], w);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, "_resp_err"}, {63'd0, resp_err}, 64'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
        chk({tag, "_dmem_en"}, {63'd0, dmem_en}, 64'd0);
        chk({tag, "_dmem_wen"}, {63'd0, dmem_wen}, 64'd0);
        chk({tag, "_dmem_addr"}, dmem_addr, 64'd0);
        chk({tag, "_dmem_wdata"}, dmem_wdata, 64'd0);
        chk({tag, "_dmem_wmask"}, dmem_wmask, 64'd0);
        chk({tag, "_perf_loads"}, {32'd0, perf_loads}, 64'd0);
        chk({tag, "_perf_stores"}, {32'd0, perf_stores}, 64'd0);
    endtask

    task automatic check_perf(input string tag, input int ld, input int st);
`ifdef LSU_PERF_CNT_EN
        chk({tag, "_perf_loads"}, {32'd0, perf_loads}, 64'(ld));
        chk({tag, "_perf_stores"}, {32'd0, perf_stores}, 64'(st));
`else
        chk({tag, "_perf_loads"}, {32'd0, perf_loads}, 64'd0 & 64'(ld));
        chk({tag, "_perf_stores"}, {32'd0, perf_stores}, 64'd0 & 64'(st));
`endif
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic        wen, sgn;
        logic [1:0]  size;
        logic [63:0] addr, wdata;
        int          off, n;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        chk("post_reset_req_ready", {63'd0, req_ready}, 64'd1);

        issue(1, c_base + 64'h10, 2'd3, 0, 64'h1122_3344_5566_7788, 0);
        issue(0, c_base + 64'h10, 2'd3, 0, 64'd0, 0);
        issue(1, c_base + 64'h17, 2'd0, 0, 64'h91, 1);
        issue(0, c_base + 64'h17, 2'd0, 1, 64'd0, 0);
        issue(0, c_base + 64'h17, 2'd0, 0, 64'd0, 0);
        issue(1, c_base + 64'h06, 2'd1, 0, 64'hBEEF, 0);
        issue(0, c_base + 64'h06, 2'd1, 0, 64'd0, 2);
        issue(0, c_base + 64'h02, 2'd2, 0, 64'd0, 0);
        issue(0, 64'h0000_0000_7FFF_FFF8, 2'd3, 0, 64'd0, 0);
        issue(1, c_base + c_size - 64'd4, 2'd2, 0, 64'hCAFE_F00D, 0);
        issue(0, c_base + c_size - 64'd8, 2'd3, 1, 64'd0, 0);
        issue(0, c_base + c_size, 2'd0, 0, 64'd0, 0);
        issue(0, c_base + c_size - 64'd4, 2'd3, 0, 64'd0, 0);
        issue(0, c_base + 64'h10, 2'd3, 0, 64'd0, 5);

        for (int r = 0; r < 80; r++) begin
            wen  = 1'($urandom % 2);
            sgn  = 1'($urandom % 2);
            size = 2'($urandom % 4);
            n    = 1 << size;
            off  = int'($urandom % 256);
            if ($urandom % 5 != 0) off = off - (off % n);
            addr = c_base + 64'(off);
            if ($urandom % 10 == 0) addr = c_base - 64'(8 * (1 + $urandom % 4));
            else if ($urandom % 10 == 0) addr = c_base + c_size + 64'(off);
            wdata = {$urandom, $urandom};
            issue(wen, addr, size, sgn, wdata, int'($urandom % 4));
        end
        check_perf("random", exp_loads, exp_stores);
        check_mem();

        // Reset during the ACCESS cycle of a store must drop the write.
        req_valid = 1; req_wen = 1; req_addr = c_base + 64'h40; req_size = 2'd3;
        req_signed = 0; req_wdata = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 0;
        chk("rst_test_in_access", {63'd0, dmem_en}, 64'd1);
        rst_n = 0;
        #1;
        check_reset_outputs("mid_access_reset");
        @(posedge clk);
        @(negedge clk); rst_n = 1;
        exp_loads = 0; exp_stores = 0;
        @(posedge clk); #1;
        chk("rst_test_req_ready", {63'd0, req_ready}, 64'd1);
        check_mem();

        issue(0, c_base + 64'h10, 2'd3, 0, 64'd0, 0);
        issue(1, c_base + 64'h20, 2'd2, 0, 64'h1234_5678, 1);
        issue(0, c_base + 64'h20, 2'd2, 1, 64'd0, 0);
        check_perf("two_loads_one_store", 2, 1);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
